// File: rtl/pixel_write_fifo.sv
// ---------------------------------------------------------------------------
// pixel_write_fifo
//
// Buffers pixels from the drawing stage and writes them into the shared
// 256x256 frame memory. Each pixel is packed to RGB332 on entry and stored
// together with its 16-bit address {Y, X}. The FIFO absorbs stalls while the
// scan-out side owns the memory. It counts pixels that arrive while it is
// full and pulses a flag when the last address of the frame has been written.
//
// Parameters
//   DEPTH      number of FIFO entries (power of two, >= 2)
//   PTR_W      log2(DEPTH), pointer width
//
// Ports
//   CLK        system clock; all state changes on the rising edge
//   NRST       synchronous active-low reset
//   iWE        pixel strobe, one pixel per cycle while high
//   iX, iY     pixel column / row
//   iR,iG,iB   pixel colour, 8 bits per channel
//   iClrOvf    clears oOverflow and oDropCnt
//   iMemAck    memory accepted the current write
//   oMemReq    write request pending (FIFO not empty)
//   oMemAddr   address of the FIFO head, {Y, X}
//   oMemData   RGB332 data of the FIFO head
//   oFull      FIFO holds DEPTH entries
//   oOverflow  sticky flag: at least one pixel was dropped
//   oDropCnt   number of dropped pixels, saturating at 16'hFFFF
//   oFrameDone one-cycle pulse after address 16'hFFFF has been written
//
// Memory handshake (oMemReq / iMemAck):
//   A write transfers on every rising edge where oMemReq and iMemAck are both
//   high. While oMemReq is high and iMemAck is low, oMemAddr and oMemData
//   hold their values. iMemAck while oMemReq is low is ignored. oMemReq and
//   the head fields come only from registers, so iMemAck can never feed back
//   combinationally into the request.
// ---------------------------------------------------------------------------
module pixel_write_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        iWE,
    input  logic [7:0]  iX,
    input  logic [7:0]  iY,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    input  logic        iClrOvf,
    input  logic        iMemAck,
    output logic        oMemReq,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oFull,
    output logic        oOverflow,
    output logic [15:0] oDropCnt,
    output logic        oFrameDone
);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [15:0]      LAST_ADDR = 16'hFFFF;

    // Entry layout: {addr[15:0], data[7:0]}
    logic [23:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;
    logic             frame_done_q;

    logic             full;
    logic             req;
    logic [23:0]      head;
    logic             push;
    logic             drop;
    logic             pop;
    logic [7:0]       rgb332;
    logic [PTR_W:0]   count_next;
    logic             overflow_next;
    logic [15:0]      drop_cnt_next;

    // Low colour bits are discarded by the RGB332 packing.
    logic unused_colour_bits;
    assign unused_colour_bits = ^{iR[4:0], iG[4:0], iB[5:0]};

    // Status decodes use registered state only.
    assign full = (count_q == DEPTH_CNT);
    assign req  = (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        push          = 1'b0;
        drop          = 1'b0;
        pop           = 1'b0;
        rgb332        = {iR[7:5], iG[7:5], iB[7:6]};
        count_next    = count_q;
        overflow_next = overflow_q;
        drop_cnt_next = drop_cnt_q;

        // Full is the value before the edge, so a strobe into a full FIFO is
        // dropped even if a pop frees a slot on the same edge.
        push = iWE && !full;
        drop = iWE && full;
        pop  = req && iMemAck;

        case ({push, pop})
            2'b10:   count_next = count_q + CNT_ONE;
            2'b01:   count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase

        // A drop on the same edge as a clear wins: the new drop is counted
        // starting from zero.
        if (drop) begin
            overflow_next = 1'b1;
            if (iClrOvf) begin
                drop_cnt_next = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_next = drop_cnt_q + 16'd1;
            end
        end else if (iClrOvf) begin
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            // Clearing every entry makes the head fields read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {iY, iX, rgb332};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q      <= count_next;
            overflow_q   <= overflow_next;
            drop_cnt_q   <= drop_cnt_next;
            frame_done_q <= pop && (head[23:8] == LAST_ADDR);
        end
    end

    assign oMemReq    = req;
    assign oMemAddr   = head[23:8];
    assign oMemData   = head[7:0];
    assign oFull      = full;
    assign oOverflow  = overflow_q;
    assign oDropCnt   = drop_cnt_q;
    assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_pixel_write_fifo.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_fifo
//
// Directed bench for pixel_write_fifo (DEPTH = 4). Inputs change 1 time unit
// after each rising edge and outputs are checked at that same point, after
// the registers have settled. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_pixel_write_fifo;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        iWE = 1'b0;
    logic [7:0]  iX = '0;
    logic [7:0]  iY = '0;
    logic [7:0]  iR = '0;
    logic [7:0]  iG = '0;
    logic [7:0]  iB = '0;
    logic        iClrOvf = 1'b0;
    logic        iMemAck = 1'b0;
    logic        oMemReq;
    logic [15:0] oMemAddr;
    logic [7:0]  oMemData;
    logic        oFull;
    logic        oOverflow;
    logic [15:0] oDropCnt;
    logic        oFrameDone;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] addr_v;
    int          fd_highs;
    int          full_highs;
    int          addr_errs;

    pixel_write_fifo #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .iWE        (iWE),
        .iX         (iX),
        .iY         (iY),
        .iR         (iR),
        .iG         (iG),
        .iB         (iB),
        .iClrOvf    (iClrOvf),
        .iMemAck    (iMemAck),
        .oMemReq    (oMemReq),
        .oMemAddr   (oMemAddr),
        .oMemData   (oMemData),
        .oFull      (oFull),
        .oOverflow  (oOverflow),
        .oDropCnt   (oDropCnt),
        .oFrameDone (oFrameDone)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1, "watchdog expired");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_px(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        iWE = 1'b1;
        iX  = x;
        iY  = y;
        iR  = r;
        iG  = g;
        iB  = b;
    endtask

    task automatic idle_px();
        iWE = 1'b0;
        iX  = '0;
        iY  = '0;
        iR  = '0;
        iG  = '0;
        iB  = '0;
    endtask

    task automatic do_reset();
        NRST = 1'b0;
        step();
        NRST = 1'b1;
    endtask

    initial begin
        // ---- reset then a single pixel ----
        NRST = 1'b0;
        step();
        step();
        NRST = 1'b1;
        check("rst_req", oMemReq, 0);
        check("rst_addr", oMemAddr, 0);
        check("rst_data", oMemData, 0);
        check("rst_full", oFull, 0);
        check("rst_ovf", oOverflow, 0);
        check("rst_dropcnt", oDropCnt, 0);
        check("rst_framedone", oFrameDone, 0);

        iMemAck = 1'b1;
        drive_px(8'h12, 8'h34, 8'hFF, 8'h00, 8'hC0);
        step();
        idle_px();
        check("one_req", oMemReq, 1);
        check("one_addr", oMemAddr, 16'h3412);
        check("one_data", oMemData, 8'hE3);
        step();
        check("one_empty", oMemReq, 0);

        // ---- stall: 6 pushes with no ack ----
        iMemAck = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_px(8'h10 + 8'(i), 8'h20, {3'(i), 5'b0}, 8'h00, 8'h00);
            step();
            if (i == 2) check("stall_notfull3", oFull, 0);
            if (i == 3) check("stall_full4", oFull, 1);
        end
        idle_px();
        check("stall_dropcnt", oDropCnt, 2);
        check("stall_ovf", oOverflow, 1);
        iMemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_req", oMemReq, 1);
            check("drain_addr", oMemAddr, {8'h20, 8'h10 + 8'(i)});
            check("drain_data", oMemData, {3'(i), 5'b0});
            step();
            if (i == 0) check("drain_full_clear", oFull, 0);
        end
        check("drain_empty", oMemReq, 0);

        // ---- full with simultaneous push and pop ----
        iClrOvf = 1'b1;
        step();
        iClrOvf = 1'b0;
        check("clr_dropcnt", oDropCnt, 0);
        check("clr_ovf", oOverflow, 0);
        iMemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_px(8'h40 + 8'(i), 8'h00, 8'h00, 8'h00, 8'h00);
            step();
        end
        check("sim_full", oFull, 1);
        drive_px(8'h99, 8'h00, 8'h00, 8'h00, 8'h00);
        iMemAck = 1'b1;
        step();
        idle_px();
        check("sim_dropcnt", oDropCnt, 1);
        check("sim_full_after", oFull, 0);
        for (int i = 1; i < 4; i++) begin
            check("sim_drain_req", oMemReq, 1);
            check("sim_drain_addr", oMemAddr, {8'h00, 8'h40 + 8'(i)});
            step();
        end
        check("sim_drain_empty", oMemReq, 0);

        // ---- iClrOvf alone, then together with a drop ----
        iMemAck = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_px(8'h50 + 8'(i), 8'h01, 8'h00, 8'h00, 8'h00);
            step();
        end
        idle_px();
        check("clr3_dropcnt", oDropCnt, 4);
        iClrOvf = 1'b1;
        step();
        check("clr_alone_dropcnt", oDropCnt, 0);
        check("clr_alone_ovf", oOverflow, 0);
        check("clr_alone_full", oFull, 1);
        check("clr_alone_head", oMemAddr, 16'h0150);
        drive_px(8'h77, 8'h01, 8'h00, 8'h00, 8'h00);
        step();
        idle_px();
        iClrOvf = 1'b0;
        check("clr_drop_dropcnt", oDropCnt, 1);
        check("clr_drop_ovf", oOverflow, 1);
        check("clr_drop_head", oMemAddr, 16'h0150);

        // ---- reset mid-operation with 3 entries of the last address ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_px(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
            step();
        end
        check("mid_req", oMemReq, 1);
        check("mid_addr", oMemAddr, 16'hFFFF);
        iMemAck = 1'b1;
        NRST = 1'b0;
        step();
        NRST = 1'b1;
        idle_px();
        iMemAck = 1'b0;
        check("mid_rst_req", oMemReq, 0);
        check("mid_rst_addr", oMemAddr, 0);
        check("mid_rst_full", oFull, 0);
        check("mid_rst_dropcnt", oDropCnt, 0);
        check("mid_rst_framedone", oFrameDone, 0);
        step();
        check("mid_rst_req2", oMemReq, 0);
        check("mid_rst_framedone2", oFrameDone, 0);

        // ---- stream a whole frame with ack held high ----
        fd_highs = 0;
        full_highs = 0;
        addr_errs = 0;
        iMemAck = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            addr_v = 16'(i);
            drive_px(addr_v[7:0], addr_v[15:8], 8'h00, 8'h00, 8'h00);
            step();
            if (oFrameDone) fd_highs++;
            if (oFull) full_highs++;
            if (oMemAddr != addr_v) addr_errs++;
        end
        idle_px();
        check("stream_fd_early", fd_highs, 0);
        check("stream_full_seen", full_highs, 0);
        check("stream_addr_errs", addr_errs, 0);
        check("stream_dropcnt", oDropCnt, 0);
        check("stream_ovf", oOverflow, 0);
        step();
        check("stream_fd_pulse", oFrameDone, 1);
        check("stream_empty", oMemReq, 0);
        step();
        check("stream_fd_end", oFrameDone, 0);
        iMemAck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
